// File: rtl/mod_time_counter.sv
// mod_time_counter: synchronous modulo-MODULUS time-unit counter stage.
// Counts on a single-cycle tick_in enable from the system clock. Supports
// up/down counting, time-set load, hold and clear. Carry, borrow, compare
// match and load-error outputs are registered single-cycle pulses. Each pulse
// lines up with the cycle in which the matching count_out value is visible.
// Stages cascade by feeding carry_out (up) or borrow_out (down) into the next
// stage's tick_in.
module mod_time_counter #(
    parameter int MODULUS   = 60,
    parameter int WIDTH     = 6,
    parameter int DOWN_EN   = 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             tick_in,
    input  logic             up_down,
    input  logic             hold,
    input  logic             clear,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] count_out,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             cmp_match,
    output logic             load_err
);

    // Wrap bounds are explicit compares, never natural WIDTH overflow.
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             match_q, match_d;
    logic             lerr_q, lerr_d;
    logic             count_up;

    // With DOWN_EN=0 the direction input is ignored, so no borrow can occur.
    assign count_up = (DOWN_EN == 0) || up_down;

    // Next-state logic: clear > load > hold > tick. Only one action per edge.
    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        match_d  = 1'b0;
        lerr_d   = 1'b0;
        if (clear) begin
            count_d = RST_V;
        end else if (load_en) begin
            if (load_val > MAX_V) begin
                lerr_d = 1'b1;
            end else begin
                count_d = load_val;
                match_d = (load_val == cmp_val);
            end
        end else if (hold) begin
            count_d = count_q;
        end else if (tick_in) begin
            if (count_q > MAX_V) begin
                // An illegal code (e.g. an upset) recovers to 0 silently.
                count_d = '0;
            end else begin
                if (count_up) begin
                    if (count_q == MAX_V) begin
                        count_d = '0;
                        carry_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d  = MAX_V;
                        borrow_d = 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                match_d = (count_d == cmp_val);
            end
        end
    end

    // State and pulse registers. Reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q  <= RST_V;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            match_q  <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            match_q  <= match_d;
            lerr_q   <= lerr_d;
        end
    end

    assign count_out  = count_q;
    assign carry_out  = carry_q;
    assign borrow_out = borrow_q;
    assign cmp_match  = match_q;
    assign load_err   = lerr_q;

endmodule

// File: tb/tb_mod_time_counter.sv
// Directed bench for mod_time_counter. It uses two instances: a default
// 60-count up/down stage, and a 24-count up-only stage.
module tb_mod_time_counter;

    logic       clk;
    logic       resetN;
    logic       tick_in, up_down, hold, clear, load_en;
    logic [5:0] load_val, cmp_val;
    logic [5:0] cnt_a;
    logic       carry_a, borrow_a, match_a, lerr_a;

    logic       b_tick;
    logic [4:0] cnt_b;
    logic       carry_b, borrow_b, match_b, lerr_b;

    int checks = 0;
    int errors = 0;

    mod_time_counter dut_a (
        .clk(clk), .resetN(resetN), .tick_in(tick_in), .up_down(up_down),
        .hold(hold), .clear(clear), .load_en(load_en), .load_val(load_val),
        .cmp_val(cmp_val), .count_out(cnt_a), .carry_out(carry_a),
        .borrow_out(borrow_a), .cmp_match(match_a), .load_err(lerr_a)
    );

    mod_time_counter #(.MODULUS(24), .WIDTH(5), .DOWN_EN(0), .RESET_VAL(0)) dut_b (
        .clk(clk), .resetN(resetN), .tick_in(b_tick), .up_down(1'b0),
        .hold(1'b0), .clear(1'b0), .load_en(1'b0), .load_val(5'd0),
        .cmp_val(5'd31), .count_out(cnt_b), .carry_out(carry_b),
        .borrow_out(borrow_b), .cmp_match(match_b), .load_err(lerr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int cnt, input bit c, input bit b,
                           input bit m, input bit e);
        check({tag, ".count"},  32'(cnt_a),    32'(cnt));
        check({tag, ".carry"},  32'(carry_a),  32'(c));
        check({tag, ".borrow"}, 32'(borrow_a), 32'(b));
        check({tag, ".match"},  32'(match_a),  32'(m));
        check({tag, ".lerr"},   32'(lerr_a),   32'(e));
    endtask

    initial begin
        resetN = 1'b0; tick_in = 1'b0; up_down = 1'b1; hold = 1'b0; clear = 1'b0;
        load_en = 1'b0; load_val = '0; cmp_val = 6'd63; b_tick = 1'b0;

        // Reset state
        #3;
        check_a("reset", 0, 0, 0, 0, 0);
        check("reset.cnt_b", 32'(cnt_b), 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        // 60 up ticks: 1..59 then wrap to 0 with a single carry
        tick_in = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            cyc();
            check_a($sformatf("up%0d", i), i % 60, i == 60, 0, 0, 0);
        end
        tick_in = 1'b0;

        // Load 0, then a down tick wraps to 59 with a borrow
        up_down = 1'b0; load_en = 1'b1; load_val = 6'd0;
        cyc(); check_a("load0", 0, 0, 0, 0, 0);
        load_en = 1'b0; tick_in = 1'b1;
        cyc(); check_a("down_wrap", 59, 0, 1, 0, 0);
        tick_in = 1'b0;
        cyc(); check_a("down_idle", 59, 0, 0, 0, 0);
        load_en = 1'b1; load_val = 6'd57;
        cyc(); check_a("load57", 57, 0, 0, 0, 0);
        load_en = 1'b0; tick_in = 1'b1;
        cyc(); check_a("down56", 56, 0, 0, 0, 0);
        tick_in = 1'b0;

        // Rejected load, then a load that matches cmp_val
        load_en = 1'b1; load_val = 6'd60;
        cyc(); check_a("load60", 56, 0, 0, 0, 1);
        load_en = 1'b0;
        cyc(); check_a("lerr_idle", 56, 0, 0, 0, 0);
        cmp_val = 6'd59; load_en = 1'b1; load_val = 6'd59;
        cyc(); check_a("load59", 59, 0, 0, 1, 0);
        load_en = 1'b0;
        cyc(); check_a("match_hold", 59, 0, 0, 0, 0);

        // Clear wins over load and tick; no match even though cmp_val is 0
        cmp_val = 6'd0; up_down = 1'b1;
        clear = 1'b1; load_en = 1'b1; load_val = 6'd30; tick_in = 1'b1;
        cyc(); check_a("clear", 0, 0, 0, 0, 0);
        clear = 1'b0; load_en = 1'b0; hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(); check_a($sformatf("hold%0d", i), 0, 0, 0, 0, 0);
        end
        hold = 1'b0; cmp_val = 6'd1;
        cyc(); check_a("tick_match", 1, 0, 0, 1, 0);
        tick_in = 1'b0;

        // Asynchronous reset in mid-cycle while a match pulse is high
        cmp_val = 6'd59; load_en = 1'b1; load_val = 6'd59;
        cyc(); check_a("pre_rst", 59, 0, 0, 1, 0);
        load_en = 1'b0;
        #2 resetN = 1'b0;
        #1 check_a("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        resetN = 1'b1; tick_in = 1'b1; up_down = 1'b1;
        cyc(); check_a("post_rst", 1, 0, 0, 0, 0);
        tick_in = 1'b0;

        // MODULUS=24 up-only stage: up_down=0 is ignored, and borrow stays 0
        b_tick = 1'b1;
        for (int i = 1; i <= 48; i++) begin
            cyc();
            check($sformatf("b%0d.count", i), 32'(cnt_b), 32'(i % 24));
            check($sformatf("b%0d.carry", i), 32'(carry_b), 32'((i % 24) == 0));
            check($sformatf("b%0d.borrow", i), 32'(borrow_b), 32'd0);
        end
        b_tick = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
